pcu_multiway: RTL and testbench
===============================

# pcu_multiway

Parametrised fetch program-counter unit for the N-way front end. It generates stride-aligned fetch requests toward the instruction bus and tracks outstanding requests in an internal address FIFO. It pairs each bus response with its originating address and per-lane valid mask, and hands that to decode. On a redirect it discards responses to already-issued stale requests, supports misaligned jump targets, and caps the number of requests in flight.

## Interface
- ADDR_W, 32, PC/address width
- NUM_WAYS, 2, instructions per fetch group; power of 2, 1..8; 4-byte instructions
- DEPTH, 4, maximum outstanding requests (address FIFO depth); power of 2, ≥2
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock, rising edge
- reset_n  in  1  reset; asynchronous, active-low
- stall_i  in  1  downstream stall; blocks new request issue only
- jump_i  in  1  redirect strobe, single cycle
- jump_addr_i  in  ADDR_W  redirect target; any 4-byte-aligned address
- req_ready_i  in  1  bus accepts request this cycle
- req_valid_o  out  1  request offered
- req_addr_o  out  ADDR_W  request address, aligned to STRIDE = NUM_WAYS*4
- resp_valid_i  in  1  bus returns data for the oldest outstanding request; no backpressure
- out_valid_o  out  1  fetch group valid toward decode, registered
- out_addr_o  out  ADDR_W  aligned address of the delivered group
- out_lane_mask_o  out  NUM_WAYS  bit i set = lane i instruction valid
- inflight_o  out  clog2(DEPTH+1)  outstanding request count
- resp_err_o  out  1  sticky: resp_valid_i received with no outstanding request

## Operation
- State: pc (ADDR_W), first_mask (NUM_WAYS), FIFO of {aligned addr, mask} with DEPTH entries, inflight counter, drop_cnt counter, err flag.
- Alignment: ALIGN = log2(STRIDE). req_addr_o = pc with low ALIGN bits cleared.
- Issue condition: req_valid_o = ~stall_i & ~jump_i & (inflight < DEPTH). This is combinational from registers and these inputs. Issue occurs when req_valid_o & req_ready_i.
- On issue: push {req_addr_o, first_mask}. Then pc <= req_addr_o + STRIDE (mod 2^ADDR_W, wrap silently) and first_mask <= all ones.
- Redirect (jump_i): pc <= jump_addr_i. first_mask <= ones with bits [lane-1:0] cleared, where lane = jump_addr_i[ALIGN-1:2]. No issue occurs in the jump cycle.
- Redirect stale tracking: drop_cnt <= inflight − (resp_valid_i ? 1 : 0). Every entry already in flight becomes stale, and so does the response popped in the jump cycle. A further jump overwrites drop_cnt with the same formula.
- Response: resp_valid_i with inflight>0 pops the FIFO head.
  - If drop_cnt>0 or jump_i is asserted: decrement drop_cnt (only when drop_cnt>0); the popped entry is discarded and out_valid_o=0 next cycle.
  - Otherwise: next cycle out_valid_o=1, with out_addr_o/out_lane_mask_o taken from the entry.
- Response with inflight=0: ignored, no pop, resp_err_o <= 1. It stays set until reset.
- inflight: +1 on issue, −1 on valid pop, unchanged on simultaneous issue+pop. Never exceeds DEPTH.
- stall_i does not affect pops or out_valid_o.

## Timing
- Reset values: pc=RESET_PC, first_mask = mask derived from RESET_PC, FIFO empty, inflight_o=0, drop_cnt=0, out_valid_o=0, out_addr_o=0, out_lane_mask_o=0, resp_err_o=0.
- req_valid_o is 0 while reset_n is low. It may assert in the first cycle after deassertion.
- Issue throughput: 1 request/cycle while req_ready_i=1 and inflight<DEPTH.
- Response to out_valid_o latency: exactly 1 cycle. out_valid_o is a one-cycle pulse per delivered group.
- Jump to first new request: req_valid_o can assert the cycle after jump_i, offering the aligned jump_addr_i.
- Reset mid-operation asynchronously clears all state, including FIFO contents and drop_cnt. Responses after reset with inflight=0 set resp_err_o.
- FIFO full (inflight=DEPTH): req_valid_o=0. A pop in cycle T allows issue in cycle T+1 (inflight is registered).

## Test plan
- Reset release, RESET_PC=0x0, NUM_WAYS=2, req_ready_i=1, responses 2 cycles later -> requests 0x0, 0x8, 0x10, … on consecutive cycles. Each response yields out_valid_o with matching address and mask 2'b11 one cycle later.
- req_ready_i=1, no responses -> exactly 4 issues, then req_valid_o=0 and inflight_o=4. One resp_valid_i -> out_addr_o=0x0, and req_valid_o re-asserts next cycle with 0x20.
- 3 outstanding (0x8, 0x10, 0x18), jump_i to 0x104 -> next request 0x100 with mask 2'b10. The next 3 responses produce no out_valid_o; the 4th delivers 0x100 / 2'b10, after which 0x108 / 2'b11 follows.
- Jump coincident with resp_valid_i, inflight=2 -> that response and one more are dropped (drop_cnt=1). The first delivered group is the jump target.
- resp_valid_i with inflight_o=0 -> no out_valid_o, resp_err_o=1 and stays set. Assert reset_n low -> resp_err_o=0, inflight_o=0.
- pc=0xFFFFFFF8, ADDR_W=32 -> next request address wraps to 0x0. stall_i=1 holds req_valid_o=0 while pending responses still deliver.

Source files
------------

// File: rtl/pcu_multiway.sv
// Fetch program-counter unit: issues stride-aligned fetch requests, tracks them in an
// address FIFO, pairs bus responses with their address/lane mask and drops stale ones after a redirect.
module pcu_multiway #(
    parameter int                ADDR_W   = 32,
    parameter int                NUM_WAYS = 2,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         stall_i,
    input  logic                         jump_i,
    input  logic [ADDR_W-1:0]            jump_addr_i,
    input  logic                         req_ready_i,
    output logic                         req_valid_o,
    output logic [ADDR_W-1:0]            req_addr_o,
    input  logic                         resp_valid_i,
    output logic                         out_valid_o,
    output logic [ADDR_W-1:0]            out_addr_o,
    output logic [NUM_WAYS-1:0]          out_lane_mask_o,
    output logic [$clog2(DEPTH+1)-1:0]   inflight_o,
    output logic                         resp_err_o
);

    localparam int STRIDE = NUM_WAYS * 4;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    // Lanes below the entry lane of a (possibly misaligned) target are invalid.
    function automatic logic [NUM_WAYS-1:0] lane_mask(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] lane;
        lane = (a >> 2) & ADDR_W'(NUM_WAYS - 1);
        return {NUM_WAYS{1'b1}} << lane;
    endfunction

    logic [ADDR_W-1:0]   pc;
    logic [NUM_WAYS-1:0] first_mask;
    logic [ADDR_W-1:0]   fifo_addr [DEPTH];
    logic [NUM_WAYS-1:0] fifo_mask [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    inflight;
    logic [CNT_W-1:0]    drop_cnt;

    logic issue;
    logic pop;
    logic drop;
    logic deliver;

    assign req_addr_o  = pc & ~ADDR_W'(STRIDE - 1);
    assign req_valid_o = reset_n & ~stall_i & ~jump_i & (inflight < CNT_W'(DEPTH));
    assign issue       = req_valid_o & req_ready_i;
    assign pop         = resp_valid_i & (inflight != '0);
    assign drop        = pop & ((drop_cnt != '0) | jump_i);
    assign deliver     = pop & ~drop;
    assign inflight_o  = inflight;

    // Request side: pc, entry mask and FIFO write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc         <= RESET_PC;
            first_mask <= lane_mask(RESET_PC);
            wr_ptr     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr[i] <= '0;
                fifo_mask[i] <= '0;
            end
        end else begin
            if (jump_i) begin
                pc         <= jump_addr_i;
                first_mask <= lane_mask(jump_addr_i);
            end else if (issue) begin
                pc         <= req_addr_o + ADDR_W'(STRIDE);
                first_mask <= '1;
            end
            if (issue) begin
                fifo_addr[wr_ptr] <= req_addr_o;
                fifo_mask[wr_ptr] <= first_mask;
                wr_ptr            <= wr_ptr + 1'b1;
            end
        end
    end

    // Tracking: occupancy, stale-response count, error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            inflight   <= '0;
            drop_cnt   <= '0;
            resp_err_o <= 1'b0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            inflight <= inflight + CNT_W'(issue) - CNT_W'(pop);
            if (jump_i)
                drop_cnt <= inflight - CNT_W'(pop);
            else if (pop && drop_cnt != '0)
                drop_cnt <= drop_cnt - 1'b1;
            if (resp_valid_i && inflight == '0)
                resp_err_o <= 1'b1;
        end
    end

    // Delivery register toward decode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_o     <= 1'b0;
            out_addr_o      <= '0;
            out_lane_mask_o <= '0;
        end else begin
            out_valid_o <= deliver;
            if (deliver) begin
                out_addr_o      <= fifo_addr[rd_ptr];
                out_lane_mask_o <= fifo_mask[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_pcu_multiway.sv
// Directed bench for pcu_multiway (ADDR_W=32, NUM_WAYS=2, DEPTH=4, RESET_PC=0).
module tb_pcu_multiway;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_i, jump_i, req_ready_i, resp_valid_i;
    logic [31:0] jump_addr_i;
    logic        req_valid_o, out_valid_o, resp_err_o;
    logic [31:0] req_addr_o, out_addr_o;
    logic [1:0]  out_lane_mask_o;
    logic [2:0]  inflight_o;

    int n_vec = 0;
    int n_err = 0;

    pcu_multiway #(.ADDR_W(32), .NUM_WAYS(2), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .jump_i(jump_i),
        .jump_addr_i(jump_addr_i), .req_ready_i(req_ready_i), .req_valid_o(req_valid_o),
        .req_addr_o(req_addr_o), .resp_valid_i(resp_valid_i), .out_valid_o(out_valid_o),
        .out_addr_o(out_addr_o), .out_lane_mask_o(out_lane_mask_o),
        .inflight_o(inflight_o), .resp_err_o(resp_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        stall_i = 0; jump_i = 0; req_ready_i = 0; resp_valid_i = 0; jump_addr_i = '0;
        step(); step();
        reset_n = 1'b1;
        settle();
    endtask

    initial begin
        do_reset();
        reset_n = 1'b0;
        settle();
        chk("rst_req_valid", req_valid_o, 0);
        chk("rst_inflight", inflight_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_addr", out_addr_o, 0);
        chk("rst_out_mask", out_lane_mask_o, 0);
        chk("rst_err", resp_err_o, 0);
        step();
        reset_n = 1'b1;
        settle();

        // Streaming: responses two cycles behind requests
        req_ready_i = 1;
        chk("s_req_valid0", req_valid_o, 1);
        chk("s_req_addr0", req_addr_o, 32'h0);
        step();
        chk("s_req_addr1", req_addr_o, 32'h8);
        step();
        resp_valid_i = 1;
        settle();
        chk("s_req_addr2", req_addr_o, 32'h10);
        step();
        chk("s_out_valid0", out_valid_o, 1);
        chk("s_out_addr0", out_addr_o, 32'h0);
        chk("s_out_mask0", out_lane_mask_o, 2'b11);
        chk("s_inflight", inflight_o, 2);
        chk("s_req_addr3", req_addr_o, 32'h18);
        step();
        chk("s_out_addr1", out_addr_o, 32'h8);
        req_ready_i = 0;
        step();
        chk("s_out_addr2", out_addr_o, 32'h10);
        step();
        chk("s_out_addr3", out_addr_o, 32'h18);
        chk("s_inflight0", inflight_o, 0);
        resp_valid_i = 0;
        step();
        chk("s_out_pulse", out_valid_o, 0);
        chk("s_no_err", resp_err_o, 0);

        // Fill to DEPTH, then one pop frees a slot
        do_reset();
        req_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("f_req_addr", req_addr_o, 64'(i * 8));
            step();
        end
        chk("f_full_valid", req_valid_o, 0);
        chk("f_full_cnt", inflight_o, 4);
        resp_valid_i = 1;
        step();
        resp_valid_i = 0;
        req_ready_i = 0;
        settle();
        chk("f_out_valid", out_valid_o, 1);
        chk("f_out_addr", out_addr_o, 32'h0);
        chk("f_reissue_valid", req_valid_o, 1);
        chk("f_reissue_addr", req_addr_o, 32'h20);
        chk("f_inflight", inflight_o, 3);

        // Redirect to misaligned target with 0x8/0x10/0x18 outstanding
        jump_i = 1; jump_addr_i = 32'h104; req_ready_i = 1;
        settle();
        chk("j_no_issue", req_valid_o, 0);
        step();
        jump_i = 0;
        settle();
        chk("j_req_valid", req_valid_o, 1);
        chk("j_req_addr", req_addr_o, 32'h100);
        step();
        req_ready_i = 0;
        chk("j_full", inflight_o, 4);
        resp_valid_i = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("j_drop", out_valid_o, 0);
        end
        step();
        resp_valid_i = 0;
        chk("j_tgt_valid", out_valid_o, 1);
        chk("j_tgt_addr", out_addr_o, 32'h100);
        chk("j_tgt_mask", out_lane_mask_o, 2'b10);
        req_ready_i = 1;
        settle();
        chk("j_next_addr", req_addr_o, 32'h108);
        step();
        req_ready_i = 0; resp_valid_i = 1;
        step();
        resp_valid_i = 0;
        chk("j_next_out", out_addr_o, 32'h108);
        chk("j_next_mask", out_lane_mask_o, 2'b11);

        // Jump coincident with a response, inflight=2
        req_ready_i = 1;
        step(); step();
        req_ready_i = 0;
        chk("c_inflight2", inflight_o, 2);
        jump_i = 1; jump_addr_i = 32'h200; resp_valid_i = 1;
        step();
        jump_i = 0; resp_valid_i = 0;
        chk("c_drop0", out_valid_o, 0);
        chk("c_inflight1", inflight_o, 1);
        req_ready_i = 1;
        settle();
        chk("c_req_addr", req_addr_o, 32'h200);
        step();
        req_ready_i = 0; resp_valid_i = 1;
        step();
        chk("c_drop1", out_valid_o, 0);
        step();
        resp_valid_i = 0;
        chk("c_deliver", out_valid_o, 1);
        chk("c_addr", out_addr_o, 32'h200);
        chk("c_mask", out_lane_mask_o, 2'b11);

        // Response with nothing outstanding; reset clears the sticky flag
        chk("e_inflight0", inflight_o, 0);
        resp_valid_i = 1;
        step();
        resp_valid_i = 0;
        chk("e_no_out", out_valid_o, 0);
        chk("e_err", resp_err_o, 1);
        step();
        chk("e_sticky", resp_err_o, 1);
        chk("e_inflight", inflight_o, 0);
        reset_n = 0;
        settle();
        chk("e_rst_err", resp_err_o, 0);
        chk("e_rst_inflight", inflight_o, 0);
        step();
        do_reset();

        // Address wrap and stall holding issue while responses drain
        jump_i = 1; jump_addr_i = 32'hFFFF_FFF8;
        step();
        jump_i = 0; req_ready_i = 1;
        settle();
        chk("w_addr0", req_addr_o, 32'hFFFF_FFF8);
        step();
        chk("w_addr1", req_addr_o, 32'h0);
        step();
        req_ready_i = 0; stall_i = 1;
        settle();
        chk("w_stall", req_valid_o, 0);
        resp_valid_i = 1;
        step();
        chk("w_out0", out_addr_o, 32'hFFFF_FFF8);
        chk("w_out0_v", out_valid_o, 1);
        chk("w_stall2", req_valid_o, 0);
        step();
        resp_valid_i = 0;
        chk("w_out1", out_addr_o, 32'h0);
        chk("w_out1_v", out_valid_o, 1);
        stall_i = 0;
        settle();
        chk("w_resume", req_valid_o, 1);
        chk("w_resume_addr", req_addr_o, 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
